pipeline_hazard_ctrl: RTL

// Sequences the IF / ID / EX / WB pipeline: RAW interlock, control-transfer handling, squash.

---
 rtl/pipeline_hazard_ctrl_if.sv | 44 ++++
 rtl/pipeline_hazard_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard controller bundle: ID-stage decode and WB redirect in,
// pipeline enables, bubbles and performance counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 6,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_rd;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_writes_rd;
  logic             id_is_ctrl;
  logic             wb_redirect;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             issue;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             redirect_err;

  modport master (
    output id_valid, id_rs, id_rt, id_rd,
    output id_uses_rs, id_uses_rt,
    output id_writes_rd, id_is_ctrl,
    output wb_redirect,
    input  pc_write, ifid_write, ifid_flush,
    input  idex_flush, issue,
    input  stall_cnt, flush_cnt, redirect_err
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd,
    input  id_uses_rs, id_uses_rt,
    input  id_writes_rd, id_is_ctrl,
    input  wb_redirect,
    output pc_write, ifid_write, ifid_flush,
    output idex_flush, issue,
    output stall_cnt, flush_cnt, redirect_err
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// IF/ID/EX/WB hazard controller: RAW interlock, branch handling, squash.
// Define SPECULATIVE_FETCH_EN for predict-not-taken instead of D1/D2 stalls.
module pipeline_hazard_ctrl #(
  parameter int REG_W    = 6,
  parameter int CNT_W    = 16,
  parameter bit ZERO_REG = 1'b1
) (
  input logic                   clock,
  input logic                   resetn,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic             writes;
    logic [REG_W-1:0] rd;
    logic             ctrl;
  } slot_t;

  slot_t            ex_q, ex_d;
  slot_t            wb_q, wb_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             err_q, err_d;

`ifndef SPECULATIVE_FETCH_EN
  typedef enum logic [1:0] {
    RUN = 2'd0,
    D1  = 2'd1,
    D2  = 2'd2
  } state_e;

  state_e state_q, state_d;
`endif

  logic pc_we, ifid_we, ifid_fl, idex_fl, iss;
  logic stall_inc, flush_inc;
  logic hazard, redir_ok, stray;

  function automatic logic hit(
    input logic [REG_W-1:0] r,
    input slot_t            s
  );
    return s.valid && s.writes && (r == s.rd)
        && !(ZERO_REG && (r == '0));
  endfunction

  assign hazard = bus.id_valid & (
    (bus.id_uses_rs &
      (hit(bus.id_rs, ex_q) | hit(bus.id_rs, wb_q))) |
    (bus.id_uses_rt &
      (hit(bus.id_rt, ex_q) | hit(bus.id_rt, wb_q))));

  assign redir_ok = bus.wb_redirect & wb_q.valid & wb_q.ctrl;
  assign stray    = bus.wb_redirect & ~(wb_q.valid & wb_q.ctrl);

  always_comb begin
    pc_we     = 1'b0;
    ifid_we   = 1'b0;
    ifid_fl   = 1'b0;
    idex_fl   = 1'b1;
    iss       = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
`ifdef SPECULATIVE_FETCH_EN
    if (redir_ok) begin
      pc_we     = 1'b1;
      ifid_fl   = 1'b1;
      flush_inc = 1'b1;
    end else if (hazard) begin
      stall_inc = 1'b1;
    end else begin
      pc_we   = 1'b1;
      ifid_we = 1'b1;
      iss     = bus.id_valid;
      idex_fl = ~bus.id_valid;
    end
`else
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (hazard) begin
          stall_inc = 1'b1;
        end else if (bus.id_valid & bus.id_is_ctrl) begin
          // hold PC until the branch resolves in WB
          ifid_fl = 1'b1;
          iss     = 1'b1;
          idex_fl = 1'b0;
          state_d = D1;
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
          iss     = bus.id_valid;
          idex_fl = ~bus.id_valid;
        end
      end
      D1: begin
        ifid_fl = 1'b1;
        state_d = D2;
      end
      D2: begin
        pc_we   = 1'b1;
        state_d = RUN;
        if (redir_ok) begin
          ifid_fl   = 1'b1;
          flush_inc = 1'b1;
        end else begin
          ifid_we = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
`endif
    if (!resetn) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      ifid_fl = 1'b1;
      idex_fl = 1'b1;
      iss     = 1'b0;
    end

    stall_d = stall_q;
    if (stall_inc && (stall_q != '1))
      stall_d = stall_q + CNT_W'(1);
    flush_d = flush_q;
    if (flush_inc && (flush_q != '1))
      flush_d = flush_q + CNT_W'(1);
    err_d = err_q | stray;

    ex_d = '0;
    if (iss) begin
      ex_d.valid  = 1'b1;
      ex_d.writes = bus.id_writes_rd;
      ex_d.rd     = bus.id_rd;
      ex_d.ctrl   = bus.id_is_ctrl;
    end
    wb_d = ex_q;
`ifdef SPECULATIVE_FETCH_EN
    // wrong-path instruction in EX never reaches WB
    if (redir_ok) wb_d = '0;
`endif
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ex_q    <= '0;
      wb_q    <= '0;
      stall_q <= '0;
      flush_q <= '0;
      err_q   <= 1'b0;
`ifndef SPECULATIVE_FETCH_EN
      state_q <= RUN;
`endif
    end else begin
      ex_q    <= ex_d;
      wb_q    <= wb_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      err_q   <= err_d;
`ifndef SPECULATIVE_FETCH_EN
      state_q <= state_d;
`endif
    end
  end

  assign bus.pc_write     = pc_we;
  assign bus.ifid_write   = ifid_we;
  assign bus.ifid_flush   = ifid_fl;
  assign bus.idex_flush   = idex_fl;
  assign bus.issue        = iss;
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;
  assign bus.redirect_err = err_q;

endmodule
